// File: rtl/uart_smg_scan_if.sv
// UART-side byte strobe and SMG pin bundle for uart_smg_scan_ctrl.
// slave = controller side, master = byte source / pin observer.
interface uart_smg_scan_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       overrun_clr;
  logic [2:0] cs;
  logic [7:0] dx;
  logic       busy;
  logic       overrun;

  modport master (
    output rx_data, rx_done, overrun_clr,
    input  cs, dx, busy, overrun
  );

  modport slave (
    input  rx_data, rx_done, overrun_clr,
    output cs, dx, busy, overrun
  );
endinterface

// File: rtl/uart_smg_scan_ctrl.sv
// Converts received bytes to 3 decimal digits (shift-add-3) and scans them onto a
// common-anode 3-digit 7-segment display with a blanking gap per digit slot.
module uart_smg_scan_ctrl #(
  parameter int SCAN_TICKS  = 50000,
  parameter int BLANK_TICKS = 500,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_smg_scan_if.slave bus
);
  localparam int TICK_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t            state_q, state_d;
  logic [7:0]        bin_q, bin_d;
  logic [11:0]       bcd_q, bcd_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [11:0]       disp_q, disp_d;
  logic [7:0]        pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              overrun_q, overrun_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [1:0]        idx_q, idx_d;
  logic [2:0]        cs_q, cs_d;
  logic [7:0]        dx_q, dx_d;

  logic [19:0] shifted;
  logic        ovr_set;
  logic        blank_h, blank_t;
  logic [7:0]  slot_code;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: seg_code = 8'hC0;
      4'd1: seg_code = 8'hF9;
      4'd2: seg_code = 8'hA4;
      4'd3: seg_code = 8'hB0;
      4'd4: seg_code = 8'h99;
      4'd5: seg_code = 8'h92;
      4'd6: seg_code = 8'h82;
      4'd7: seg_code = 8'hF8;
      4'd8: seg_code = 8'h80;
      4'd9: seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Conversion engine with 1-deep pending byte
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ovr_set    = 1'b0;
    shifted    = {add3(bcd_q), bin_q} << 1;
    case (state_q)
      IDLE: begin
        // A pending byte only survives into IDLE when it arrived during a bare COMMIT
        if (pend_vld_q) begin
          bin_d      = pend_q;
          bcd_d      = '0;
          cnt_d      = '0;
          state_d    = SHIFT;
          pend_vld_d = bus.rx_done;
          if (bus.rx_done) pend_d = bus.rx_data;
        end else if (bus.rx_done) begin
          bin_d   = bus.rx_data;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = shifted[19:8];
        bin_d = shifted[7:0];
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = COMMIT;
        if (bus.rx_done) begin
          pend_d     = bus.rx_data;
          pend_vld_d = 1'b1;
          ovr_set    = pend_vld_q;
        end
      end
      COMMIT: begin
        disp_d = bcd_q;
        if (pend_vld_q) begin
          bin_d      = pend_q;
          bcd_d      = '0;
          cnt_d      = '0;
          state_d    = SHIFT;
          pend_vld_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
        if (bus.rx_done) begin
          pend_d     = bus.rx_data;
          pend_vld_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    overrun_d = ovr_set | (overrun_q & ~bus.overrun_clr);
  end

  // Free-running scan scheduler; the pattern is latched once at the end of the blank gap
  always_comb begin
    tick_d    = tick_q + TICK_W'(1);
    idx_d     = idx_q;
    cs_d      = cs_q;
    dx_d      = dx_q;
    blank_h   = LZ_BLANK && (disp_q[11:8] == 4'd0);
    blank_t   = blank_h && (disp_q[7:4] == 4'd0);
    slot_code = 8'hFF;
    if (tick_q == TICK_W'(SCAN_TICKS - 1)) begin
      tick_d = '0;
      idx_d  = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
    case (idx_d)
      2'd0:    slot_code = seg_code(disp_q[3:0]);
      2'd1:    slot_code = blank_t ? 8'hFF : seg_code(disp_q[7:4]);
      2'd2:    slot_code = blank_h ? 8'hFF : seg_code(disp_q[11:8]);
      default: slot_code = 8'hFF;
    endcase
    if (tick_d < TICK_W'(BLANK_TICKS)) begin
      cs_d = 3'b111;
    end else if (tick_d == TICK_W'(BLANK_TICKS)) begin
      cs_d = ~(3'b001 << idx_d);
      dx_d = slot_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      disp_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
      tick_q     <= '0;
      idx_q      <= '0;
      cs_q       <= 3'b111;
      dx_q       <= 8'hFF;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      overrun_q  <= overrun_d;
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      cs_q       <= cs_d;
      dx_q       <= dx_d;
    end
  end

  assign bus.cs      = cs_q;
  assign bus.dx      = dx_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_uart_smg_scan_ctrl.sv
// Bench for uart_smg_scan_ctrl: two instances (leading-zero blanking on/off) compared
// every cycle against a decimal-arithmetic reference model, plus fixed-value checks.
module tb_uart_smg_scan_ctrl;
  localparam int ST = 20;
  localparam int BT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       ovr_clr = 1'b0;

  int checks = 0;
  int passes = 0;

  // Reference model state
  int unsigned n;
  int          m_rem;
  int          m_disp;
  logic [7:0]  m_cur, m_pend;
  bit          m_pvld, m_ovr;
  logic [2:0]  m_cs;
  logic [7:0]  m_dx_a, m_dx_b;

  logic [7:0] obs_a [3];
  logic [7:0] obs_b [3];
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  always #5 clk = ~clk;

  uart_smg_scan_if bus_a ();
  uart_smg_scan_if bus_b ();

  assign bus_a.rx_data     = rx_data;
  assign bus_a.rx_done     = rx_done;
  assign bus_a.overrun_clr = ovr_clr;
  assign bus_b.rx_data     = rx_data;
  assign bus_b.rx_done     = rx_done;
  assign bus_b.overrun_clr = ovr_clr;

  uart_smg_scan_ctrl #(.SCAN_TICKS(ST), .BLANK_TICKS(BT), .LZ_BLANK(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  uart_smg_scan_ctrl #(.SCAN_TICKS(ST), .BLANK_TICKS(BT), .LZ_BLANK(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  function automatic logic [7:0] digit_pat(input int v, input int pos, input bit lz);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    case (pos)
      0:       return seg_tab[o];
      1:       return (lz && h == 0 && t == 0) ? 8'hFF : seg_tab[t];
      default: return (lz && h == 0) ? 8'hFF : seg_tab[h];
    endcase
  endfunction

  // Model: a byte occupies the converter for 9 cycles, then its decimal value is shown.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; m_rem = 0; m_disp = 0; m_cur = 0; m_pend = 0;
      m_pvld = 0; m_ovr = 0; m_cs = 3'b111; m_dx_a = 8'hFF; m_dx_b = 8'hFF;
    end else begin : step
      int tk, ix;
      bit set_ovr;
      n++;
      tk = n % ST;
      ix = (n / ST) % 3;
      if (tk < BT) m_cs = 3'b111;
      else if (tk == BT) begin
        m_cs   = ~(3'b001 << ix);
        m_dx_a = digit_pat(m_disp, ix, 1'b1);
        m_dx_b = digit_pat(m_disp, ix, 1'b0);
      end
      set_ovr = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_disp = m_cur;
          if (m_pvld) begin m_cur = m_pend; m_rem = 9; m_pvld = 0; end
        end
        if (rx_done) begin set_ovr = m_pvld; m_pend = rx_data; m_pvld = 1; end
      end else if (m_pvld) begin
        m_cur = m_pend; m_rem = 9; m_pvld = 0;
        if (rx_done) begin m_pend = rx_data; m_pvld = 1; end
      end else if (rx_done) begin
        m_cur = rx_data; m_rem = 9;
      end
      if (set_ovr) m_ovr = 1;
      else if (ovr_clr) m_ovr = 0;
    end
  end

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({bus_a.cs, bus_a.dx, bus_a.busy, bus_a.overrun} !== {3'b111, 8'hFF, 1'b0, 1'b0})
        $display("FAIL reset_state got cs=%b dx=%h busy=%b ovr=%b, want 111 ff 0 0",
                 bus_a.cs, bus_a.dx, bus_a.busy, bus_a.overrun);
      else passes++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      checks++;
      if ({bus_a.cs, bus_a.dx, bus_a.busy, bus_a.overrun} !== {m_cs, m_dx_a, (m_rem > 0), m_ovr})
        $display("FAIL reset_scan n=%0d got cs=%b dx=%h busy=%b ovr=%b, want cs=%b dx=%h busy=%b ovr=%b",
                 n, bus_a.cs, bus_a.dx, bus_a.busy, bus_a.overrun, m_cs, m_dx_a, m_rem > 0, m_ovr);
      else passes++;
      checks++;
      if ({bus_b.cs, bus_b.dx} !== {m_cs, m_dx_b})
        $display("FAIL reset_scan_nolz n=%0d got cs=%b dx=%h, want cs=%b dx=%h",
                 n, bus_b.cs, bus_b.dx, m_cs, m_dx_b);
      else passes++;
      if (n == 3 || n == 4 || n == 10 || n == 19 || n == 20 || n == 30 || n == 50) begin
        logic [10:0] want;
        case (n)
          3, 20:   want = {3'b111, 8'hFF};
          19:      want = {3'b110, 8'hC0};
          4, 10:   want = {3'b110, 8'hC0};
          30:      want = {3'b101, 8'hFF};
          default: want = {3'b011, 8'hFF};
        endcase
        if (n == 20) want[7:0] = 8'hC0;
        checks++;
        if ({bus_a.cs, bus_a.dx} !== want)
          $display("FAIL reset_slot n=%0d got cs=%b dx=%h, want cs=%b dx=%h",
                   n, bus_a.cs, bus_a.dx, want[10:8], want[7:0]);
        else passes++;
      end
    end
  endtask

  task automatic test_byte(input logic [7:0] val, input logic [7:0] eh, et, eo, nh, nt, no_);
    int unsigned n0;
    logic [7:0] ea [3];
    logic [7:0] eb [3];
    ea[0] = eo; ea[1] = et; ea[2] = eh;
    eb[0] = no_; eb[1] = nt; eb[2] = nh;
    rx_data = val; rx_done = 1'b1; n0 = n;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      rx_done = 1'b0;
      checks++;
      if ({bus_a.cs, bus_a.dx, bus_a.busy, bus_a.overrun} !== {m_cs, m_dx_a, (m_rem > 0), m_ovr})
        $display("FAIL byte_%0d n=%0d got cs=%b dx=%h busy=%b ovr=%b, want cs=%b dx=%h busy=%b ovr=%b",
                 val, n, bus_a.cs, bus_a.dx, bus_a.busy, bus_a.overrun, m_cs, m_dx_a, m_rem > 0, m_ovr);
      else passes++;
      checks++;
      if ({bus_b.cs, bus_b.dx} !== {m_cs, m_dx_b})
        $display("FAIL byte_%0d_nolz n=%0d got cs=%b dx=%h, want cs=%b dx=%h",
                 val, n, bus_b.cs, bus_b.dx, m_cs, m_dx_b);
      else passes++;
      if (n == n0 + 1 || n == n0 + 9 || n == n0 + 10) begin
        checks++;
        if (bus_a.busy !== (n != n0 + 10))
          $display("FAIL busy_window byte=%0d cycle=%0d got busy=%b want %b",
                   val, n - n0, bus_a.busy, n != n0 + 10);
        else passes++;
      end
      if (n % ST == 10) begin
        obs_a[(n / ST) % 3] = bus_a.dx;
        obs_b[(n / ST) % 3] = bus_b.dx;
      end
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs_a[d] !== ea[d]) $display("FAIL digit_%0d byte=%0d got %h want %h", d, val, obs_a[d], ea[d]);
      else passes++;
      checks++;
      if (obs_b[d] !== eb[d]) $display("FAIL digit_%0d_nolz byte=%0d got %h want %h", d, val, obs_b[d], eb[d]);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    int unsigned n0;
    logic [7:0] ea [3];
    ea[0] = 8'h82; ea[1] = 8'h92; ea[2] = 8'hFF;
    rx_data = 8'd12; rx_done = 1'b1; n0 = n;
    for (int c = 0; c < 110; c++) begin
      @(negedge clk);
      rx_data = (c == 0) ? 8'd34 : 8'd56;
      rx_done = (c < 2);
      ovr_clr = (c == 40);
      checks++;
      if ({bus_a.cs, bus_a.dx, bus_a.busy, bus_a.overrun} !== {m_cs, m_dx_a, (m_rem > 0), m_ovr})
        $display("FAIL b2b n=%0d got cs=%b dx=%h busy=%b ovr=%b, want cs=%b dx=%h busy=%b ovr=%b",
                 n, bus_a.cs, bus_a.dx, bus_a.busy, bus_a.overrun, m_cs, m_dx_a, m_rem > 0, m_ovr);
      else passes++;
      checks++;
      if ({bus_b.cs, bus_b.dx} !== {m_cs, m_dx_b})
        $display("FAIL b2b_nolz n=%0d got cs=%b dx=%h, want cs=%b dx=%h",
                 n, bus_b.cs, bus_b.dx, m_cs, m_dx_b);
      else passes++;
      if (n == n0 + 2 || n == n0 + 3 || n == n0 + 42) begin
        checks++;
        if (bus_a.overrun !== (n == n0 + 3))
          $display("FAIL overrun_seq cycle=%0d got %b want %b", n - n0, bus_a.overrun, n == n0 + 3);
        else passes++;
      end
      if (n == n0 + 18 || n == n0 + 19) begin
        checks++;
        if (bus_a.busy !== (n == n0 + 18))
          $display("FAIL b2b_busy cycle=%0d got %b want %b", n - n0, bus_a.busy, n == n0 + 18);
        else passes++;
      end
      if (n % ST == 10) obs_a[(n / ST) % 3] = bus_a.dx;
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs_a[d] !== ea[d]) $display("FAIL b2b_digit_%0d got %h want %h", d, obs_a[d], ea[d]);
      else passes++;
    end
  endtask

  task automatic test_mid_slot();
    int unsigned base;
    for (int c = 0; c < 61 && (n % 60) != 0; c++) @(negedge clk);
    checks++;
    if ((n % 60) != 0) $display("FAIL mid_slot_align n=%0d got phase %0d want 0", n, n % 60);
    else passes++;
    base = n;
    rx_data = 8'd200; rx_done = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      rx_done = 1'b0;
      checks++;
      if ({bus_a.cs, bus_a.dx, bus_a.busy, bus_a.overrun} !== {m_cs, m_dx_a, (m_rem > 0), m_ovr})
        $display("FAIL mid_slot n=%0d got cs=%b dx=%h busy=%b ovr=%b, want cs=%b dx=%h busy=%b ovr=%b",
                 n, bus_a.cs, bus_a.dx, bus_a.busy, bus_a.overrun, m_cs, m_dx_a, m_rem > 0, m_ovr);
      else passes++;
      if (n == base + 15 || n == base + 50 || n == base + 70) begin
        logic [7:0] want;
        want = (n == base + 15) ? 8'h82 : (n == base + 50) ? 8'hA4 : 8'hC0;
        checks++;
        if (bus_a.dx !== want)
          $display("FAIL mid_slot_dx cycle=%0d got %h want %h", n - base, bus_a.dx, want);
        else passes++;
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      checks++;
      if ({bus_a.cs, bus_a.dx, bus_a.busy, bus_a.overrun} !== {m_cs, m_dx_a, (m_rem > 0), m_ovr})
        $display("FAIL random n=%0d got cs=%b dx=%h busy=%b ovr=%b, want cs=%b dx=%h busy=%b ovr=%b",
                 n, bus_a.cs, bus_a.dx, bus_a.busy, bus_a.overrun, m_cs, m_dx_a, m_rem > 0, m_ovr);
      else passes++;
      checks++;
      if ({bus_b.cs, bus_b.dx} !== {m_cs, m_dx_b})
        $display("FAIL random_nolz n=%0d got cs=%b dx=%h, want cs=%b dx=%h",
                 n, bus_b.cs, bus_b.dx, m_cs, m_dx_b);
      else passes++;
      rx_data = 8'($urandom);
      rx_done = (c < 660) && ($urandom_range(0, (c < 330) ? 11 : 3) == 0);
      ovr_clr = ($urandom_range(0, 19) == 0);
    end
    ovr_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    rx_data = 8'd99; rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus_a.busy !== 1'b1) $display("FAIL reset_mid_busy_before got %b want 1", bus_a.busy);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_a.cs, bus_a.dx, bus_a.busy, bus_a.overrun} !== {3'b111, 8'hFF, 1'b0, 1'b0})
      $display("FAIL reset_mid_now got cs=%b dx=%h busy=%b ovr=%b, want 111 ff 0 0",
               bus_a.cs, bus_a.dx, bus_a.busy, bus_a.overrun);
    else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      checks++;
      if ({bus_a.cs, bus_a.dx, bus_a.busy, bus_a.overrun} !== {m_cs, m_dx_a, (m_rem > 0), m_ovr})
        $display("FAIL reset_mid n=%0d got cs=%b dx=%h busy=%b ovr=%b, want cs=%b dx=%h busy=%b ovr=%b",
                 n, bus_a.cs, bus_a.dx, bus_a.busy, bus_a.overrun, m_cs, m_dx_a, m_rem > 0, m_ovr);
      else passes++;
      if (n == 10 || n == 30 || n == 50 || n == 70) begin
        logic [7:0] want;
        want = (n == 10 || n == 70) ? 8'hC0 : 8'hFF;
        checks++;
        if ({bus_a.dx, bus_a.busy} !== {want, 1'b0})
          $display("FAIL reset_mid_disp n=%0d got dx=%h busy=%b want dx=%h busy=0",
                   n, bus_a.dx, bus_a.busy, want);
        else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte(8'hFF, 8'hA4, 8'h92, 8'h92, 8'hA4, 8'h92, 8'h92);
    test_byte(8'd105, 8'hF9, 8'hC0, 8'h92, 8'hF9, 8'hC0, 8'h92);
    test_byte(8'd7, 8'hFF, 8'hFF, 8'hF8, 8'hC0, 8'hC0, 8'hF8);
    test_byte(8'd0, 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    test_back_to_back();
    test_mid_slot();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/uart_smg_scan_ctrl.md
Name: uart_smg_scan_ctrl

Overview:
- Sequences a 3-digit common-anode 7-segment display from bytes delivered by the UART receiver.
- Each received byte is converted to decimal 000..255 by a sequential shift-add-3 (double-dabble) engine. The result is committed to a display buffer.
- A time-multiplexed scan scheduler drives the digit selects and segment lines, with a blanking gap between digits and optional leading-zero suppression.
- Sits between the UART receiver (rx_data/rx_done) and the board SMG pins.

Parameters:
- SCAN_TICKS, 50000, clk cycles per digit slot (1 ms at 50 MHz); must be > BLANK_TICKS.
- BLANK_TICKS, 500, cycles at the start of each slot with all digits off.
- LZ_BLANK, 1, 1 = suppress leading zeros on hundreds/tens digits; 0 = always show 3 digits.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte; valid only when rx_done=1.
- rx_done  in  1  one-cycle strobe, byte available.
- overrun_clr  in  1  synchronous clear of overrun.
- cs  out  3  digit select, active low; cs[0]=ones, cs[1]=tens, cs[2]=hundreds.
- dx  out  8  segment pattern, active low, bit7=dp (dp always off=1).
- busy  out  1  conversion engine active.
- overrun  out  1  sticky: a pending byte was overwritten.

Behaviour:
- Reset (async, all registers):
  - cs=3'b111, dx=8'hFF, busy=0, overrun=0.
  - Display buffer = 0,0,0; pending empty; FSM=IDLE; tick=0; digit index=0.
- Segment codes:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Blank=FF. Codes >9 cannot occur; map any to FF.
- Conversion FSM: IDLE, SHIFT, COMMIT.
  - IDLE: on rx_done, load rx_data into 8-bit bin shift reg, clear 12-bit BCD reg, bit count=0, go to SHIFT.
  - SHIFT, 8 cycles: each cycle add 3 to any BCD nibble >=5, then shift {bcd,bin} left by 1. After the 8th shift go to COMMIT.
  - COMMIT, 1 cycle: copy BCD to display buffer.
    - If pending valid: load pending into bin, clear BCD, clear pending, go to SHIFT.
    - Otherwise go to IDLE.
- Latency: rx_done sampled at edge k in IDLE -> display buffer holds new value after edge k+9.
- busy=1 exactly while FSM != IDLE (registered with state); 9 cycles per byte.
- Pending buffer, 1 deep:
  - rx_done while FSM != IDLE stores the byte in pending.
  - If pending is already valid, the new byte overwrites it and overrun sets at the next edge.
  - rx_done in the same cycle as COMMIT-with-pending: the old pending byte is consumed and the new byte becomes pending; no overrun.
- overrun_clr clears overrun. If overrun_clr and a set event occur in the same cycle, the set wins.
- Scan scheduler, free-running and independent of the FSM:
  - tick counts 0..SCAN_TICKS-1 and wraps.
  - On wrap, digit index advances 0 -> 1 -> 2 -> 0.
- Slot outputs (registered):
  - While tick < BLANK_TICKS: cs=111. dx holds its previous value (not displayed).
  - At tick==BLANK_TICKS, at the next edge: cs = one-hot-low of the index (110/101/011) and dx = code of the indexed digit.
  - Both hold until slot end. The pattern is latched once per slot, so a commit mid-slot appears no earlier than the next slot.
  - At tick==SCAN_TICKS-1, at the next edge: cs=111.
- Leading-zero suppression (LZ_BLANK=1):
  - Hundreds==0 -> hundreds digit shows FF.
  - Hundreds==0 and tens==0 -> tens digit shows FF.
  - Ones always shown. Value 0 shows "  0"; 105 shows "105" (inner zero kept).
  - A blanked digit still gets cs asserted (uniform brightness timing).
- Reset mid-conversion: returns immediately to reset values. The partial conversion and pending byte are discarded; the display reverts to 0.

Test Plan (SCAN_TICKS=20, BLANK_TICKS=4):
- Reset release, no rx -> cs cycles 111 (4 cycles), then 110 (16 cycles), then 111/101…; dx=C0 in the ones slot and FF in the tens and hundreds slots. busy=0.
- rx_done with 8'hFF at edge k -> busy high k+1..k+9; buffer=2,5,5 after k+9; next full scan shows dx 92 (ones), 92 (tens), A4 (hundreds).
- Byte 105 with LZ_BLANK=1 -> hundreds F9, tens C0, ones 92. Byte 7 -> hundreds FF, tens FF, ones F8. With LZ_BLANK=0 byte 7 -> C0, C0, F8.
- Bytes 12, 34, 56 on consecutive cycles -> 12 converted; 34 is overwritten by 56 in pending and overrun=1 one cycle later. Final display 056 after 18 cycles. overrun_clr -> overrun=0.
- Byte 200 committed at tick=10 of the ones slot -> dx unchanged until the next ones slot, then C0. Hundreds slot shows A4.
- Assert rst_n=0 at cycle 4 of SHIFT for byte 99 -> immediately cs=111, dx=FF, busy=0. After release, display shows "  0" and no late commit occurs.
